// File: rtl/gpu_sim_pkg.sv
// ============================================================================
// Package : gpu_sim_pkg
// Brief   : Shared constants, instruction/task field positions and FSM states
//           for the 8-lane SIMT simulation top.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gpu_sim_pkg;

  localparam int LANES        = 8;
  localparam int NUM_VREGS    = 8;
  localparam int WORD_W       = 32;
  localparam int ICACHE_DEPTH = 1024;
  localparam int TM_DEPTH     = 256;
  localparam int TASK_W       = 29;

  // Instruction fields
  localparam int F_OP_MSB  = 31;
  localparam int F_OP_LSB  = 28;
  localparam int F_RD_MSB  = 27;
  localparam int F_RD_LSB  = 25;
  localparam int F_RS1_MSB = 24;
  localparam int F_RS1_LSB = 22;
  localparam int F_RS2_MSB = 21;
  localparam int F_RS2_LSB = 19;
  localparam int F_IMM_MSB = 15;
  localparam int F_IMM_LSB = 0;

  // Task-queue entry fields
  localparam int T_PC_MSB   = 9;
  localparam int T_PC_LSB   = 0;
  localparam int T_MASK_MSB = 17;
  localparam int T_MASK_LSB = 10;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_EXIT = 4'd1;
  localparam logic [3:0] OP_LD   = 4'd2;
  localparam logic [3:0] OP_ST   = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_BNZ  = 4'd6;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FETCH   = 3'd1;
  localparam state_t ST_EXEC    = 3'd2;
  localparam state_t ST_MEMWAIT = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  function automatic logic [WORD_W-1:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpu_sim_latency_filter.sv
// ============================================================================
// Module  : gpu_sim_latency_filter
// Brief   : Per-row miss-latency table plus direct-mapped hit filter; reports
//           how many wait cycles an access to a data-memory row costs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gpu_sim_latency_filter #(
  parameter  int MEM_SIZE   = 256,
  parameter  int SHMEM_SIZE = 256,
  parameter  int CACHE_SIZE = 64,
  localparam int MA         = $clog2(MEM_SIZE),
  localparam int AW         = $clog2(MEM_SIZE + SHMEM_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_lat_we,
  input  logic [MA-1:0] i_lat_addr,
  input  logic [4:0]    i_lat_value,
  input  logic [AW-1:0] i_addr,
  input  logic          i_fill,
  output logic [5:0]    o_stall
);
  import gpu_sim_pkg::*;

  localparam int CW = (CACHE_SIZE > 1) ? $clog2(CACHE_SIZE) : 1;
  localparam logic [AW-1:0] c_shmem_base = AW'(MEM_SIZE);

  logic [4:0]            r_lat   [MEM_SIZE];
  // Full global row address is kept as the tag so any cache_size <= mem_size works
  logic [MA-1:0]         r_tag   [CACHE_SIZE];
  logic [CACHE_SIZE-1:0] r_valid;

  logic          w_shared;
  logic          w_hit;
  logic [MA-1:0] w_gaddr;
  logic [CW-1:0] w_slot;

  assign w_gaddr  = i_addr[MA-1:0];
  assign w_slot   = w_gaddr[CW-1:0];
  assign w_shared = (i_addr >= c_shmem_base);
  assign w_hit    = r_valid[w_slot] && (r_tag[w_slot] == w_gaddr);
  assign o_stall  = (w_shared || w_hit) ? 6'd0 : 6'd1 + {1'b0, r_lat[w_gaddr]};

  always_ff @(posedge clk) begin
    if (i_lat_we) begin
      r_lat[i_lat_addr] <= i_lat_value;
    end
    if (i_fill && !w_shared) begin
      r_tag[w_slot] <= w_gaddr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_fill && !w_shared) begin
      r_valid[w_slot] <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gpu_sim_top.sv
// ============================================================================
// Module  : gpu_sim_top
// Brief   : 8-lane SIMT core with task manager, ICache, global/shared memory
//           and cache-latency emulation, all loaded through file-IO ports.
// Options : GPU_TRACE_EN - per-instruction $display trace (simulation only)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gpu_sim_top #(
  parameter  int MEM_SIZE   = 256,
  parameter  int SHMEM_SIZE = 256,
  parameter  int CACHE_SIZE = 64,
  localparam int MA         = $clog2(MEM_SIZE),
  localparam int AW         = $clog2(MEM_SIZE + SHMEM_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Write_Enable_FIO_TM,
  input  logic [28:0]   Write_Data_FIO_TM,
  input  logic          start_FIO_TM,
  input  logic          clear_FIO_TM,
  output logic          finished_TM_FIO,
  input  logic          FileIO_Wen_ICache,
  input  logic [9:0]    FileIO_Addr_ICache,
  input  logic [31:0]   FileIO_Din_ICache,
  output logic [31:0]   FileIO_Dout_ICache,
  input  logic          FIO_MEMWRITE,
  input  logic [AW-1:0] FIO_ADDR,
  input  logic [255:0]  FIO_WRITE_DATA,
  output logic [255:0]  FIO_READ_DATA,
  input  logic          FIO_CACHE_LAT_WRITE,
  input  logic [4:0]    FIO_CACHE_LAT_VALUE,
  input  logic [MA-1:0] FIO_CACHE_MEM_ADDR
);
  import gpu_sim_pkg::*;

  localparam int         c_rows    = MEM_SIZE + SHMEM_SIZE;
  localparam logic [8:0] c_tm_full = 9'(TM_DEPTH);

  logic [TASK_W-1:0]       r_tq     [TM_DEPTH];
  logic [31:0]             r_icache [ICACHE_DEPTH];
  logic [LANES*WORD_W-1:0] r_mem    [c_rows];
  logic [WORD_W-1:0]       r_vreg   [NUM_VREGS][LANES];

  logic [8:0]        r_tq_count;
  logic [31:0]       r_icache_dout;
  logic [255:0]      r_fio_rdata;
  state_t            r_state;
  logic              r_finished;
  logic [7:0]        r_task_idx;
  logic [9:0]        r_pc;
  logic [LANES-1:0]  r_mask;
  logic [31:0]       r_instr;
  logic [5:0]        r_wait;

  logic [3:0]        w_op;
  logic [2:0]        w_rd, w_rs1, w_rs2;
  logic [15:0]       w_imm;
  logic [AW-1:0]     w_addr;
  logic [2:0]        w_unused_instr;
  logic              w_is_ld, w_is_st, w_is_mem;
  logic [5:0]        w_stall;
  logic              w_mem_done;
  logic              w_fill;
  logic              w_last_task;
  logic              w_start_ok;
  logic              w_launch;
  logic [7:0]        w_launch_idx;
  logic [TASK_W-1:0] w_entry;
  logic [10:0]       w_unused_rsvd;
  logic              w_tq_we;
  logic              w_core_we;
  logic              w_wb_en;
  logic [WORD_W-1:0] w_wb_data [LANES];
  logic [255:0]      w_mem_row;
  logic [255:0]      w_st_row;

  assign w_op           = r_instr[F_OP_MSB:F_OP_LSB];
  assign w_rd           = r_instr[F_RD_MSB:F_RD_LSB];
  assign w_rs1          = r_instr[F_RS1_MSB:F_RS1_LSB];
  assign w_rs2          = r_instr[F_RS2_MSB:F_RS2_LSB];
  assign w_imm          = r_instr[F_IMM_MSB:F_IMM_LSB];
  assign w_addr         = w_imm[AW-1:0];
  assign w_unused_instr = r_instr[18:16];

  assign w_is_ld  = (w_op == OP_LD);
  assign w_is_st  = (w_op == OP_ST);
  assign w_is_mem = w_is_ld || w_is_st;

  // A file-IO write owns the single row write port, so a pending core store waits
  assign w_mem_done = w_is_mem && !(w_is_st && FIO_MEMWRITE) &&
                      (((r_state == ST_EXEC) && (w_stall == 6'd0)) ||
                       ((r_state == ST_MEMWAIT) && (r_wait == 6'd0)));
  assign w_fill     = w_mem_done && !clear_FIO_TM;

  assign w_last_task   = (({1'b0, r_task_idx} + 9'd1) >= r_tq_count);
  assign w_start_ok    = (r_state == ST_IDLE) && start_FIO_TM && !r_finished;
  assign w_launch      = !clear_FIO_TM &&
                         ((w_start_ok && (r_tq_count != 9'd0)) ||
                          ((r_state == ST_EXEC) && (w_op == OP_EXIT) && !w_last_task));
  assign w_launch_idx  = (r_state == ST_IDLE) ? 8'd0 : r_task_idx + 8'd1;
  assign w_entry       = r_tq[w_launch_idx];
  assign w_unused_rsvd = w_entry[28:18];

  assign w_tq_we   = Write_Enable_FIO_TM && !clear_FIO_TM && (r_tq_count < c_tm_full);
  assign w_core_we = w_fill && w_is_st;
  assign w_wb_en   = !clear_FIO_TM &&
                     (((r_state == ST_EXEC) && ((w_op == OP_ADD) || (w_op == OP_ADDI))) ||
                      (w_mem_done && w_is_ld));
  assign w_mem_row = r_mem[w_addr];

  assign finished_TM_FIO    = r_finished;
  assign FIO_READ_DATA      = r_fio_rdata;
  assign FileIO_Dout_ICache = r_icache_dout;

  gpu_sim_latency_filter #(
    .MEM_SIZE   (MEM_SIZE),
    .SHMEM_SIZE (SHMEM_SIZE),
    .CACHE_SIZE (CACHE_SIZE)
  ) u_lat_filter (
    .clk         (clk),
    .rst         (rst),
    .i_lat_we    (FIO_CACHE_LAT_WRITE),
    .i_lat_addr  (FIO_CACHE_MEM_ADDR),
    .i_lat_value (FIO_CACHE_LAT_VALUE),
    .i_addr      (w_addr),
    .i_fill      (w_fill),
    .o_stall     (w_stall)
  );

  always_comb begin
    w_st_row = w_mem_row;
    for (int i = 0; i < LANES; i++) begin
      w_wb_data[i] = w_mem_row[i*WORD_W +: WORD_W];
      if (r_mask[i]) begin
        w_st_row[i*WORD_W +: WORD_W] = r_vreg[w_rs1][i];
      end
      if (w_op == OP_ADD) begin
        w_wb_data[i] = r_vreg[w_rs1][i] + r_vreg[w_rs2][i];
      end else if (w_op == OP_ADDI) begin
        w_wb_data[i] = r_vreg[w_rs1][i] + sext16(w_imm);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Write_Enable_FIO_TM && w_tq_we) begin
      r_tq[r_tq_count[7:0]] <= Write_Data_FIO_TM;
    end
    if (FileIO_Wen_ICache) begin
      r_icache[FileIO_Addr_ICache] <= FileIO_Din_ICache;
    end
    if (FIO_MEMWRITE) begin
      r_mem[FIO_ADDR] <= FIO_WRITE_DATA;
    end else if (w_core_we) begin
      r_mem[w_addr] <= w_st_row;
    end
  end

  // Launch seeds R1 with the lane number and R2 with the task index
  always_ff @(posedge clk) begin
    if (w_launch) begin
      for (int r = 0; r < NUM_VREGS; r++) begin
        for (int i = 0; i < LANES; i++) begin
          r_vreg[r][i] <= (r == 1) ? 32'(i) : (r == 2) ? {24'd0, w_launch_idx} : '0;
        end
      end
    end else if (w_wb_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (r_mask[i]) begin
          r_vreg[w_rd][i] <= w_wb_data[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_finished    <= 1'b0;
      r_tq_count    <= 9'd0;
      r_task_idx    <= 8'd0;
      r_pc          <= 10'd0;
      r_mask        <= '0;
      r_instr       <= 32'd0;
      r_wait        <= 6'd0;
      r_fio_rdata   <= '0;
      r_icache_dout <= 32'd0;
    end else begin
      r_fio_rdata   <= r_mem[FIO_ADDR];
      r_icache_dout <= r_icache[FileIO_Addr_ICache];
      if (clear_FIO_TM) begin
        r_tq_count <= 9'd0;
        r_finished <= 1'b0;
        r_state    <= ST_IDLE;
      end else begin
        if (w_tq_we) begin
          r_tq_count <= r_tq_count + 9'd1;
        end
        if (w_launch) begin
          r_task_idx <= w_launch_idx;
          r_pc       <= w_entry[T_PC_MSB:T_PC_LSB];
          r_mask     <= w_entry[T_MASK_MSB:T_MASK_LSB];
        end
        case (r_state)
          ST_IDLE: begin
            if (w_start_ok) begin
              if (r_tq_count == 9'd0) begin
                r_state    <= ST_DONE;
                r_finished <= 1'b1;
              end else begin
                r_state <= ST_FETCH;
              end
            end
          end
          ST_FETCH: begin
            r_instr <= r_icache[r_pc];
            r_state <= ST_EXEC;
          end
          ST_EXEC: begin
            if (w_is_mem) begin
              if (w_mem_done) begin
                r_pc    <= r_pc + 10'd1;
                r_state <= ST_FETCH;
              end else begin
                r_state <= ST_MEMWAIT;
                r_wait  <= (w_stall == 6'd0) ? 6'd0 : w_stall - 6'd1;
              end
            end else if (w_op == OP_EXIT) begin
              if (w_last_task) begin
                r_state    <= ST_DONE;
                r_finished <= 1'b1;
              end else begin
                r_state <= ST_FETCH;
              end
            end else if ((w_op == OP_BNZ) && (r_vreg[w_rs1][0] != 32'd0)) begin
              r_pc    <= w_imm[9:0];
              r_state <= ST_FETCH;
            end else begin
              r_pc    <= r_pc + 10'd1;
              r_state <= ST_FETCH;
            end
          end
          ST_MEMWAIT: begin
            if (r_wait != 6'd0) begin
              r_wait <= r_wait - 6'd1;
            end else if (w_mem_done) begin
              r_pc    <= r_pc + 10'd1;
              r_state <= ST_FETCH;
            end
          end
          ST_DONE:  r_state <= ST_DONE;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef GPU_TRACE_EN
  logic [5:0] r_trace_stall;
  logic       r_trace_fin;

  always_ff @(posedge clk) begin
    r_trace_fin <= r_finished;
    if (r_state == ST_FETCH) begin
      r_trace_stall <= 6'd0;
    end else if (r_state == ST_MEMWAIT) begin
      r_trace_stall <= r_trace_stall + 6'd1;
    end
    if (rst && !clear_FIO_TM &&
        (((r_state == ST_EXEC) && !w_is_mem) || w_mem_done)) begin
      $display("[gpu_trace] task=%0d pc=%0d op=%0d stall=%0d", r_task_idx, r_pc, w_op,
               (r_state == ST_MEMWAIT) ? r_trace_stall + 6'd1 : 6'd0);
    end
    if (rst && r_finished && !r_trace_fin) begin
      $display("[gpu_trace] finished");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpu_sim_top.sv
// ============================================================================
// Module  : tb_gpu_sim_top
// Brief   : Directed self-checking bench for gpu_sim_top.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpu_sim_top;
  import gpu_sim_pkg::*;

  localparam int MEM_SIZE = 256;
  localparam int AW       = 9;
  localparam int MA       = 8;

  logic          clk_tb = 1'b0;
  logic          rst;
  logic          Write_Enable_FIO_TM;
  logic [28:0]   Write_Data_FIO_TM;
  logic          start_FIO_TM;
  logic          clear_FIO_TM;
  logic          finished_TM_FIO;
  logic          FileIO_Wen_ICache;
  logic [9:0]    FileIO_Addr_ICache;
  logic [31:0]   FileIO_Din_ICache;
  logic [31:0]   FileIO_Dout_ICache;
  logic          FIO_MEMWRITE;
  logic [AW-1:0] FIO_ADDR;
  logic [255:0]  FIO_WRITE_DATA;
  logic [255:0]  FIO_READ_DATA;
  logic          FIO_CACHE_LAT_WRITE;
  logic [4:0]    FIO_CACHE_LAT_VALUE;
  logic [MA-1:0] FIO_CACHE_MEM_ADDR;

  int total = 0;
  int bad   = 0;

  gpu_sim_top dut (
    .clk                 (clk_tb),
    .rst                 (rst),
    .Write_Enable_FIO_TM (Write_Enable_FIO_TM),
    .Write_Data_FIO_TM   (Write_Data_FIO_TM),
    .start_FIO_TM        (start_FIO_TM),
    .clear_FIO_TM        (clear_FIO_TM),
    .finished_TM_FIO     (finished_TM_FIO),
    .FileIO_Wen_ICache   (FileIO_Wen_ICache),
    .FileIO_Addr_ICache  (FileIO_Addr_ICache),
    .FileIO_Din_ICache   (FileIO_Din_ICache),
    .FileIO_Dout_ICache  (FileIO_Dout_ICache),
    .FIO_MEMWRITE        (FIO_MEMWRITE),
    .FIO_ADDR            (FIO_ADDR),
    .FIO_WRITE_DATA      (FIO_WRITE_DATA),
    .FIO_READ_DATA       (FIO_READ_DATA),
    .FIO_CACHE_LAT_WRITE (FIO_CACHE_LAT_WRITE),
    .FIO_CACHE_LAT_VALUE (FIO_CACHE_LAT_VALUE),
    .FIO_CACHE_MEM_ADDR  (FIO_CACHE_MEM_ADDR)
  );

  always #5 clk_tb = ~clk_tb;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, 3'b000, imm};
  endfunction

  task automatic write_icache(input int addr, input logic [31:0] data);
    FileIO_Wen_ICache = 1'b1; FileIO_Addr_ICache = 10'(addr); FileIO_Din_ICache = data;
    @(negedge clk_tb);
    FileIO_Wen_ICache = 1'b0;
  endtask

  task automatic write_mem(input int row, input logic [255:0] data);
    FIO_MEMWRITE = 1'b1; FIO_ADDR = 9'(row); FIO_WRITE_DATA = data;
    @(negedge clk_tb);
    FIO_MEMWRITE = 1'b0;
  endtask

  task automatic read_mem(input int row, output logic [255:0] data);
    FIO_ADDR = 9'(row);
    @(negedge clk_tb);
    data = FIO_READ_DATA;
  endtask

  task automatic write_lat(input int idx, input logic [4:0] v);
    FIO_CACHE_LAT_WRITE = 1'b1; FIO_CACHE_MEM_ADDR = 8'(idx); FIO_CACHE_LAT_VALUE = v;
    @(negedge clk_tb);
    FIO_CACHE_LAT_WRITE = 1'b0;
  endtask

  task automatic push_task(input int pc, input logic [7:0] mask);
    Write_Enable_FIO_TM = 1'b1; Write_Data_FIO_TM = {11'd0, mask, 10'(pc)};
    @(negedge clk_tb);
    Write_Enable_FIO_TM = 1'b0;
  endtask

  task automatic do_clear();
    clear_FIO_TM = 1'b1;
    @(negedge clk_tb);
    clear_FIO_TM = 1'b0;
  endtask

  // cyc counts rising edges from the one that samples start up to the one raising finished
  task automatic run_prog(input int limit, output int cyc);
    start_FIO_TM = 1'b1;
    @(negedge clk_tb);
    start_FIO_TM = 1'b0;
    cyc = 1;
    while (!finished_TM_FIO && cyc < limit) begin
      @(negedge clk_tb);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    logic [255:0] row;
    rst = 1'b0;
    Write_Enable_FIO_TM = 1'b0; Write_Data_FIO_TM = '0; start_FIO_TM = 1'b0;
    clear_FIO_TM = 1'b0; FileIO_Wen_ICache = 1'b0; FileIO_Addr_ICache = '0;
    FileIO_Din_ICache = '0; FIO_MEMWRITE = 1'b0; FIO_ADDR = '0; FIO_WRITE_DATA = '0;
    FIO_CACHE_LAT_WRITE = 1'b0; FIO_CACHE_LAT_VALUE = '0; FIO_CACHE_MEM_ADDR = '0;
    repeat (3) @(negedge clk_tb);
    check("rst_finished", 256'(finished_TM_FIO), 256'(0));
    check("rst_fio_rdata", FIO_READ_DATA, 256'(0));
    check("rst_icache_dout", 256'(FileIO_Dout_ICache), 256'(0));
    check("rst_state", 256'(dut.r_state), 256'(ST_IDLE));
    rst = 1'b1;
    @(negedge clk_tb);
    for (int i = 0; i < MEM_SIZE; i++) write_lat(i, 5'd0);

    // Full-mask LD/ADDI/ST
    write_mem(1, {8{32'h5}});
    write_icache(0, ins(OP_LD,   3'd3, 3'd0, 3'd0, 16'd1));
    write_icache(1, ins(OP_ADDI, 3'd3, 3'd3, 3'd0, 16'd2));
    write_icache(2, ins(OP_ST,   3'd0, 3'd3, 3'd0, 16'd16));
    write_icache(3, ins(OP_EXIT, 3'd0, 3'd0, 3'd0, 16'd0));
    FileIO_Addr_ICache = 10'd0;
    @(negedge clk_tb);
    check("icache_readback", 256'(FileIO_Dout_ICache), 256'(32'h2600_0001));
    push_task(0, 8'hFF);
    run_prog(200, cyc);
    check("t1_cycles", 256'(cyc), 256'(11));
    check("t1_finished", 256'(finished_TM_FIO), 256'(1));
    read_mem(16, row);
    check("t1_row16", row, {8{32'h7}});

    // Half mask, filter now hot for rows 1 and 16
    do_clear();
    write_mem(16, {8{32'hFFFF_FFFF}});
    push_task(0, 8'h0F);
    run_prog(200, cyc);
    check("t2_cycles", 256'(cyc), 256'(9));
    read_mem(16, row);
    check("t2_row16", row, {{4{32'hFFFF_FFFF}}, {4{32'h7}}});

    // Miss latency, hit, and eviction via row 1+cache_size
    @(negedge clk_tb); rst = 1'b0;
    @(negedge clk_tb); rst = 1'b1;
    write_lat(1, 5'd10);
    write_icache(100, ins(OP_LD,   3'd3, 3'd0, 3'd0, 16'd1));
    write_icache(101, ins(OP_EXIT, 3'd0, 3'd0, 3'd0, 16'd0));
    push_task(100, 8'hFF);
    run_prog(200, cyc);
    check("t3_miss_cycles", 256'(cyc), 256'(16));
    do_clear();
    push_task(100, 8'hFF);
    run_prog(200, cyc);
    check("t3_hit_cycles", 256'(cyc), 256'(5));
    write_icache(200, ins(OP_LD,   3'd4, 3'd0, 3'd0, 16'd65));
    write_icache(201, ins(OP_LD,   3'd3, 3'd0, 3'd0, 16'd1));
    write_icache(202, ins(OP_EXIT, 3'd0, 3'd0, 3'd0, 16'd0));
    do_clear();
    push_task(200, 8'hFF);
    run_prog(200, cyc);
    check("t3_evict_cycles", 256'(cyc), 256'(19));

    // Shared memory store: no stall
    write_icache(300, ins(OP_ST,   3'd0, 3'd1, 3'd0, 16'(MEM_SIZE + 3)));
    write_icache(301, ins(OP_EXIT, 3'd0, 3'd0, 3'd0, 16'd0));
    do_clear();
    push_task(300, 8'hFF);
    run_prog(200, cyc);
    check("t4_cycles", 256'(cyc), 256'(5));
    read_mem(MEM_SIZE + 3, row);
    check("t4_shared_row", row, {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0});

    // Three tasks, each stores its index
    do_clear();
    for (int t = 0; t < 3; t++) begin
      write_mem(20 + t, {8{32'hFFFF_FFFF}});
      write_icache(400 + 2*t, ins(OP_ST,   3'd0, 3'd2, 3'd0, 16'(20 + t)));
      write_icache(401 + 2*t, ins(OP_EXIT, 3'd0, 3'd0, 3'd0, 16'd0));
      push_task(400 + 2*t, 8'hFF);
    end
    run_prog(200, cyc);
    check("t5_cycles", 256'(cyc), 256'(16));
    check("t5_finished", 256'(finished_TM_FIO), 256'(1));
    read_mem(20, row); check("t5_row20", row, {8{32'h0}});
    read_mem(21, row); check("t5_row21", row, {8{32'h1}});
    read_mem(22, row); check("t5_row22", row, {8{32'h2}});
    do_clear();
    check("t5_cleared", 256'(finished_TM_FIO), 256'(0));

    // Empty queue, then reset during an endless loop
    run_prog(10, cyc);
    check("t6_empty_fast", 256'(cyc <= 2), 256'(1));
    check("t6_empty_finished", 256'(finished_TM_FIO), 256'(1));
    do_clear();
    write_icache(500, ins(OP_ADDI, 3'd5, 3'd0, 3'd0, 16'd1));
    write_icache(501, ins(OP_BNZ,  3'd0, 3'd5, 3'd0, 16'd501));
    push_task(500, 8'hFF);
    run_prog(20, cyc);
    check("t6_loop_running", 256'(finished_TM_FIO), 256'(0));
    rst = 1'b0;
    #1;
    check("t6_rst_finished", 256'(finished_TM_FIO), 256'(0));
    check("t6_rst_state", 256'(dut.r_state), 256'(ST_IDLE));
    @(negedge clk_tb); rst = 1'b1;
    read_mem(MEM_SIZE + 3, row);
    check("t6_mem_retained", row, {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0});

    // ADD / negative ADDI
    write_icache(600, ins(OP_ADD,  3'd4, 3'd1, 3'd2, 16'd0));
    write_icache(601, ins(OP_ADDI, 3'd4, 3'd4, 3'd0, 16'hFFFF));
    write_icache(602, ins(OP_ST,   3'd0, 3'd4, 3'd0, 16'd30));
    write_icache(603, ins(OP_EXIT, 3'd0, 3'd0, 3'd0, 16'd0));
    push_task(600, 8'hFF);
    run_prog(200, cyc);
    check("t7_cycles", 256'(cyc), 256'(10));
    read_mem(30, row);
    check("t7_row30", row, {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'hFFFF_FFFF});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
